// File: rtl/mem_copy_engine.sv
// Single-port-pair RAM block copy engine: moves length words from src_addr to dst_addr,
// choosing copy direction so overlapping ranges copy correctly. Optional MEM_COPY_CHECKSUM_EN adds a checksum output.
module mem_copy_engine #(
    parameter int addr_width = 8,
    parameter int data_width = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [addr_width-1:0] src_addr,
    input  logic [addr_width-1:0] dst_addr,
    input  logic [addr_width:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [addr_width-1:0] mem_read_addr,
    input  logic [data_width-1:0] mem_read_data,
    output logic [addr_width-1:0] mem_write_addr,
    output logic [data_width-1:0] mem_write_data,
    output logic                  mem_pw
`ifdef MEM_COPY_CHECKSUM_EN
    ,
    output logic [data_width-1:0] checksum
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        COPY,
        DONE
    } state_e;

    localparam logic [addr_width-1:0] addr_one  = 1;
    localparam logic [addr_width:0]   count_one = 1;

    state_e                state_q, state_d;
    logic [addr_width-1:0] rd_addr_q, rd_addr_d;
    logic [addr_width-1:0] offset_q, offset_d;
    logic [addr_width:0]   count_q, count_d;
    logic                  desc_q, desc_d;

    logic [addr_width-1:0] diff;
    logic                  desc_req;
    logic                  start_ok;

    // A destination that starts inside the source window must be walked top-down.
    assign diff     = dst_addr - src_addr;
    assign desc_req = ({1'b0, diff} < length) && (diff != '0);
    assign start_ok = (state_q == IDLE) && start;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        offset_d  = offset_q;
        count_d   = count_q;
        desc_d    = desc_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if ((length != '0) && (diff != '0)) begin
                        state_d   = COPY;
                        offset_d  = diff;
                        count_d   = length;
                        desc_d    = desc_req;
                        rd_addr_d = desc_req ? src_addr + length[addr_width-1:0] - addr_one
                                             : src_addr;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            COPY: begin
                // The address is left on the final word so it holds once idle.
                if (count_q == count_one) begin
                    state_d = DONE;
                end else begin
                    count_d   = count_q - count_one;
                    rd_addr_d = desc_q ? rd_addr_q - addr_one : rd_addr_q + addr_one;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rd_addr_q <= '0;
            offset_q  <= '0;
            count_q   <= '0;
            desc_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            offset_q  <= offset_d;
            count_q   <= count_d;
            desc_q    <= desc_d;
        end
    end

    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign mem_pw         = (state_q == COPY);
    assign mem_read_addr  = rd_addr_q;
    assign mem_write_addr = rd_addr_q + offset_q;
    assign mem_write_data = mem_read_data;

`ifdef MEM_COPY_CHECKSUM_EN
    logic [data_width-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (start_ok) begin
            sum_d = '0;
        end else if (state_q == COPY) begin
            sum_d = sum_q + mem_read_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: behavioural RAM, per-word reference model, directed and random copies.
module tb_mem_copy_engine;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  src_addr = '0;
    logic [7:0]  dst_addr = '0;
    logic [8:0]  length = '0;
    logic        busy, done, mem_pw;
    logic [7:0]  mem_read_addr, mem_write_addr;
    logic [31:0] mem_read_data, mem_write_data;
`ifdef MEM_COPY_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    logic [31:0] ram     [DEPTH];
    logic [31:0] exp_mem [DEPTH];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_sum = '0;
    logic [7:0]  last_rd = '0;
    logic [7:0]  last_wr = '0;

    mem_copy_engine #(
        .addr_width(8),
        .data_width(32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .src_addr      (src_addr),
        .dst_addr      (dst_addr),
        .length        (length),
        .busy          (busy),
        .done          (done),
        .mem_read_addr (mem_read_addr),
        .mem_read_data (mem_read_data),
        .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data),
        .mem_pw        (mem_pw)
`ifdef MEM_COPY_CHECKSUM_EN
        ,
        .checksum      (checksum)
`endif
    );

    always #5 clk = ~clk;

    assign mem_read_data = ram[mem_read_addr];

    always @(negedge clk) begin
        if (mem_pw) ram[mem_write_addr] <= mem_write_data;
        else if (pre_we) ram[pre_addr] <= pre_data;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [31:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        exp_mem[a] = d;
        @(posedge clk);
        #1;
        pre_we = 1'b0;
    endtask

    task automatic check_ram(input string tag);
        int diffs;
        diffs = 0;
        for (int i = 0; i < DEPTH; i++) if (ram[i] !== exp_mem[i]) diffs++;
        check(tag, diffs, 0);
    endtask

    task automatic check_sum(input string tag);
`ifdef MEM_COPY_CHECKSUM_EN
        check(tag, checksum, exp_sum);
`else
        if (tag.len() == 0) $display("empty tag");
`endif
    endtask

    // Model: word k moves in order, read then write, using the direction rule on captured arguments.
    task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [8:0] len,
                            input bit interfere);
        logic [7:0] rd_q[$];
        logic [7:0] wr_q[$];
        int diff, n, r, w;
        bit desc;
        diff = (int'(d) - int'(s)) & 255;
        desc = (diff < int'(len)) && (diff != 0);
        n = (len == 0 || s == d) ? 0 : int'(len);
        exp_sum = '0;
        for (int k = 0; k < n; k++) begin
            if (desc) begin
                r = (int'(s) + int'(len) - 1 - k) & 255;
                w = (int'(d) + int'(len) - 1 - k) & 255;
            end else begin
                r = (int'(s) + k) & 255;
                w = (int'(d) + k) & 255;
            end
            rd_q.push_back(8'(r));
            wr_q.push_back(8'(w));
            exp_mem[w] = exp_mem[r];
            exp_sum += exp_mem[w];
        end

        start = 1'b1; src_addr = s; dst_addr = d; length = len;
        @(posedge clk);
        #1;
        start = 1'b0;
        src_addr = 8'($urandom); dst_addr = 8'($urandom); length = 9'($urandom_range(0, 256));

        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            check("copy_pw", mem_pw, 1);
            check("copy_busy_done", {busy, done}, 2'b10);
            check("copy_rd_addr", mem_read_addr, rd_q[c]);
            check("copy_wr_addr", mem_write_addr, wr_q[c]);
            if (interfere && c == 1) begin
                start = 1'b1;
                src_addr = 8'($urandom); dst_addr = 8'($urandom); length = 9'($urandom_range(1, 64));
            end
            @(posedge clk);
            #1;
            start = 1'b0;
        end

        @(negedge clk);
        check("done_cycle", {busy, done, mem_pw}, 3'b110);
        check_sum("done_checksum");
        @(posedge clk);
        #1;
        if (n > 0) begin
            last_rd = rd_q[n-1];
            last_wr = wr_q[n-1];
        end
        @(negedge clk);
        check("idle_flags", {busy, done, mem_pw}, 3'b000);
        check("idle_rd_hold", mem_read_addr, last_rd);
        check("idle_wr_hold", mem_write_addr, last_wr);
        check_sum("idle_checksum");
        check_ram("ram_image");
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] s, d;
        logic [8:0] len;

        #12;
        check("reset_flags", {busy, done, mem_pw}, 3'b000);
        check("reset_rd_addr", mem_read_addr, 8'h00);
        check("reset_wr_addr", mem_write_addr, 8'h00);
        check_sum("reset_checksum");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) poke(8'(i), $urandom);

        // Simple forward copy with a known sum.
        for (int i = 0; i < 4; i++) poke(8'(8'h10 + i), 32'(i + 1));
        run_copy(8'h10, 8'h40, 9'd4, 1'b0);
        for (int i = 0; i < 4; i++) check("req031_word", ram[8'h40 + i], 32'(i + 1));
`ifdef MEM_COPY_CHECKSUM_EN
        check("req031_sum", checksum, 32'd10);
`endif

        // Overlapping destination above source.
        for (int i = 0; i < 4; i++) poke(8'(8'h10 + i), 32'(i + 1));
        run_copy(8'h10, 8'h12, 9'd4, 1'b0);
        for (int i = 0; i < 4; i++) check("req032_word", ram[8'h12 + i], 32'(i + 1));

        run_copy(8'hFE, 8'h20, 9'd4, 1'b0);
        run_copy(8'h30, 8'h50, 9'd0, 1'b0);
        run_copy(8'h05, 8'h05, 9'd3, 1'b0);
        run_copy(8'h60, 8'h70, 9'd8, 1'b1);

        for (int t = 0; t < 20; t++) begin
            s = 8'($urandom);
            case ($urandom_range(0, 2))
                0:       d = 8'($urandom);
                1:       d = s + 8'($urandom_range(0, 8));
                default: d = s - 8'($urandom_range(0, 8));
            endcase
            len = 9'($urandom_range(0, 20));
            run_copy(s, d, len, t[0]);
        end

        s = 8'($urandom);
        run_copy(s, s + 8'd3, 9'd256, 1'b0);

        // Start held high: ignored while busy, relaunches once idle.
        exp_sum = '0;
        start = 1'b1; src_addr = 8'h01; dst_addr = 8'h02; length = 9'd0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("hold_done1", {busy, done}, 2'b11);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("hold_idle", {busy, done}, 2'b00);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("hold_done2", {busy, done}, 2'b11);
        check_sum("hold_checksum");
        start = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("hold_end_idle", {busy, done}, 2'b00);
        @(posedge clk);
        #1;

        // Reset after two of eight words.
        exp_mem[8'h90] = exp_mem[8'h80];
        exp_mem[8'h91] = exp_mem[8'h81];
        start = 1'b1; src_addr = 8'h80; dst_addr = 8'h90; length = 9'd8;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("pre_reset_pw", mem_pw, 1);
        rst_n = 1'b0;
        #1;
        check("abort_flags", {busy, done, mem_pw}, 3'b000);
        check("abort_rd_addr", mem_read_addr, 8'h00);
        check("abort_wr_addr", mem_write_addr, 8'h00);
        exp_sum = '0;
        check_sum("abort_checksum");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        last_rd = '0;
        last_wr = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("after_reset_flags", {busy, done, mem_pw}, 3'b000);
            @(posedge clk);
            #1;
        end
        check_ram("abort_ram_image");

        run_copy(8'hA0, 8'hC0, 9'd5, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 SHALL have parameter addr_width, default 8, word-address width of the attached RAM.
REQ-002 SHALL have parameter data_width, default 32, word width of the attached RAM.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk input 1 (all state on posedge), rst_n input 1 (asynchronous, active-low).
REQ-004 start  input  1  copy request, sampled only in IDLE.
REQ-005 src_addr  input  addr_width  first source word address.
REQ-006 dst_addr  input  addr_width  first destination word address.
REQ-007 length  input  addr_width+1  word count, 0..2**addr_width.
REQ-008 busy  output  1  high in states other than IDLE.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 mem_read_addr  output  addr_width  drives RAM read port 1 address.
REQ-011 mem_read_data  input  data_width  combinational RAM read data for mem_read_addr.
REQ-012 mem_write_addr  output  addr_width  drives RAM write port 1 address.
REQ-013 mem_write_data  output  data_width  drives RAM write port 1 data.
REQ-014 mem_pw  output  1  RAM write enable; the RAM commits on the negedge of the same cycle.

Function
REQ-015 SHALL implement states IDLE, COPY, DONE.
REQ-016 IDLE: start=1 captures src_addr, dst_addr, length and sets direction; next state COPY if length!=0 and dst_addr!=src_addr, else DONE.
REQ-017 Direction SHALL be descending iff ((dst_addr-src_addr) mod 2**addr_width) < length and dst_addr!=src_addr; otherwise ascending.
REQ-018 Ascending: word k (k=0..length-1) read at src+k, written at dst+k; descending: k read at src+length-1-k, written at dst+length-1-k; all addresses mod 2**addr_width.
REQ-019 COPY: exactly one word per cycle; mem_pw=1, mem_write_data=mem_read_data (combinational), mem_write_addr=mem_read_addr+(dst-src).
REQ-020 COPY SHALL last exactly length cycles, then go to DONE.
REQ-021 DONE SHALL last one cycle with done=1, busy=1, mem_pw=0, then go to IDLE.
REQ-022 Latency: start accepted at edge N gives mem_pw high for cycles N+1..N+length and done in cycle N+length+1; length=0 or src==dst gives done in cycle N+1 with no writes.
REQ-023 start while busy SHALL be ignored; start held high in IDLE after done SHALL launch a new copy.
REQ-024 mem_pw SHALL be 0 outside COPY; mem_read_addr/mem_write_addr SHALL hold their last values in IDLE.
REQ-025 length=2**addr_width SHALL copy the whole memory once, with no early termination on address wrap.

Reset
REQ-026 rst_n low SHALL force IDLE immediately, asynchronously; busy=0, done=0, mem_pw=0, mem_read_addr=0, mem_write_addr=0.
REQ-027 Reset during COPY SHALL abort without further writes; words already written remain; no done pulse.

Configuration
REQ-028 With MEM_COPY_CHECKSUM_EN defined, output checksum (data_width) SHALL be the mod-2**data_width sum of all words written in the last copy.
REQ-029 checksum SHALL be cleared on start acceptance and on reset, be valid from the done cycle, and hold until the next accepted start.
REQ-030 Without MEM_COPY_CHECKSUM_EN, the checksum port and its logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-031 RAM[0x10..0x13]=1,2,3,4; src=0x10 dst=0x40 len=4 -> RAM[0x40..0x43]=1,2,3,4, done in cycle N+5, checksum=10 when enabled.
REQ-032 RAM[0x10..0x13]=1,2,3,4; src=0x10 dst=0x12 len=4 -> descending copy, RAM[0x12..0x15]=1,2,3,4.
REQ-033 src=0xFE dst=0x20 len=4 -> reads 0xFE,0xFF,0x00,0x01; writes 0x20..0x23.
REQ-034 len=0, then src=dst=0x05 len=3 -> mem_pw never high; done at N+1 in both cases.
REQ-035 rst_n low after 2 of 8 words -> mem_pw=0 immediately, only 2 words written, no done; after reset, busy=0.
REQ-036 start pulsed during COPY with different args -> ignored; the original copy completes unchanged.
